// File: rtl/y86_mem_sys.sv
// Memory subsystem behind the y86 core bus: byte-addressed RAM plus a memory-mapped TX FIFO.
// Optional read/write performance counters are enabled with Y86_MEM_PERF_EN.
module y86_mem_sys #(
  parameter int unsigned ADDR_W     = 12,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_A,
  input  logic        bus_RE,
  input  logic        bus_WE,
  input  logic [31:0] bus_out,
  output logic [31:0] bus_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err
);

  localparam int unsigned RamBytes = 2 ** ADDR_W;
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;

  logic              ram_hit, io_hit;
  logic [1:0]        io_off;
  logic [ADDR_W-1:0] a0, a1, a2, a3;

  assign ram_hit = (bus_A >> ADDR_W) == 32'd0;
  assign io_hit  = bus_A[31:4] == IO_BASE[31:4];
  assign io_off  = bus_A[3:2];

  // Lane addresses wrap at the top of RAM so unaligned fetches near the end stay in range.
  assign a0 = bus_A[ADDR_W-1:0];
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);

  logic [7:0] mem_q [RamBytes];

  always_ff @(posedge clk) begin
    if (bus_WE && ram_hit) begin
      mem_q[a0] <= bus_out[7:0];
      mem_q[a1] <= bus_out[15:8];
      mem_q[a2] <= bus_out[23:16];
      mem_q[a3] <= bus_out[31:24];
    end
  end

  // TX FIFO
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;
  logic            full, empty, push_req, push, pop;

  assign full     = count_q == CntW'(FIFO_DEPTH);
  assign empty    = count_q == '0;
  assign push_req = bus_WE && io_hit && (io_off == 2'd0);
  assign pop      = !empty && tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push     = push_req && (!full || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    err_d = err_q | (push_req && full && !pop) | (!ram_hit && !io_hit && (bus_WE || bus_RE));
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus_out[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign err      = err_q;

  logic [31:0] perf_rd, perf_wr;

`ifdef Y86_MEM_PERF_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q + {31'h0, bus_RE};
    wr_cnt_d = wr_cnt_q + {31'h0, bus_WE};
    if (bus_WE && io_hit && (io_off == 2'd2)) rd_cnt_d = '0;
    if (bus_WE && io_hit && (io_off == 2'd3)) wr_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign perf_rd = rd_cnt_q;
  assign perf_wr = wr_cnt_q;
`else
  assign perf_rd = '0;
  assign perf_wr = '0;
`endif

  always_comb begin
    bus_in = '0;
    if (bus_RE) begin
      if (ram_hit) begin
        bus_in = {mem_q[a3], mem_q[a2], mem_q[a1], mem_q[a0]};
      end else if (io_hit) begin
        unique case (io_off)
          2'd0: bus_in = '0;
          2'd1: bus_in = {16'h0, 8'(count_q), 6'h0, full, empty};
          2'd2: bus_in = perf_rd;
          2'd3: bus_in = perf_wr;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_y86_mem_sys.sv
// Randomized and directed bench for y86_mem_sys against a queue/array reference model.
// Honours Y86_MEM_PERF_EN to match the build of the design.
module tb_y86_mem_sys;

  localparam logic [31:0] IoBase = 32'hFFFF_FF00;
  localparam int          RamN   = 4096;
  localparam int          Depth  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_A, bus_out, bus_in;
  logic        bus_RE, bus_WE;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, err;

  int checks = 0;
  int failures = 0;

  y86_mem_sys dut (
    .clk     (clk),
    .rst     (rst),
    .bus_A   (bus_A),
    .bus_RE  (bus_RE),
    .bus_WE  (bus_WE),
    .bus_out (bus_out),
    .bus_in  (bus_in),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_ram   [RamN];
  bit          m_known [RamN];
  logic [7:0]  m_q[$];
  bit          m_err;
  logic [31:0] m_rd, m_wr;
  bit          m_full, m_pop;
  int          m_idx;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit is_io(input logic [31:0] a);
    return a[31:4] == IoBase[31:4];
  endfunction

  // Returns 0 when the expected read depends on never-written RAM bytes.
  function automatic bit mdl_read(input logic [31:0] a, input logic re, output logic [31:0] v);
    int idx;
    bit ok;
    v  = '0;
    ok = 1'b1;
    if (re) begin
      if (a < RamN) begin
        for (int i = 0; i < 4; i++) begin
          idx = int'((a + 32'(i)) % 32'(RamN));
          if (!m_known[idx]) ok = 1'b0;
          v[8*i +: 8] = m_ram[idx];
        end
      end else if (is_io(a)) begin
        case (a[3:2])
          2'd1: v = {16'h0, 8'(m_q.size()), 6'h0, m_q.size() == Depth, m_q.size() == 0};
`ifdef Y86_MEM_PERF_EN
          2'd2: v = m_rd;
          2'd3: v = m_wr;
`endif
          default: v = '0;
        endcase
      end
    end
    return ok;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_err = 1'b0;
      m_rd  = '0;
      m_wr  = '0;
    end else begin
      m_full = m_q.size() == Depth;
      m_pop  = (m_q.size() != 0) && tx_ready;
      if (m_pop) void'(m_q.pop_front());
      if (bus_WE && bus_A < RamN) begin
        for (int i = 0; i < 4; i++) begin
          m_idx = int'((bus_A + 32'(i)) % 32'(RamN));
          m_ram[m_idx]   = bus_out[8*i +: 8];
          m_known[m_idx] = 1'b1;
        end
      end
      if (bus_WE && is_io(bus_A) && bus_A[3:2] == 2'd0) begin
        if (!m_full || m_pop) m_q.push_back(bus_out[7:0]);
        else m_err = 1'b1;
      end
      if ((bus_RE || bus_WE) && !(bus_A < RamN) && !is_io(bus_A)) m_err = 1'b1;
      if (bus_RE) m_rd = m_rd + 32'd1;
      if (bus_WE) m_wr = m_wr + 32'd1;
      if (bus_WE && is_io(bus_A) && bus_A[3:2] == 2'd2) m_rd = '0;
      if (bus_WE && is_io(bus_A) && bus_A[3:2] == 2'd3) m_wr = '0;
    end
  end

  // Compare process: outputs are settled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] ev;
    chk("tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
    if (m_q.size() != 0) chk("tx_data", {24'h0, tx_data}, {24'h0, m_q[0]});
    chk("err", {31'h0, err}, {31'h0, m_err});
    if (mdl_read(bus_A, bus_RE, ev)) chk("bus_in", bus_in, ev);
  end

  task automatic idle();
    bus_A   = '0;
    bus_RE  = 1'b0;
    bus_WE  = 1'b0;
    bus_out = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_A = a; bus_out = d; bus_WE = 1'b1; bus_RE = 1'b0;
    step();
    idle();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus_A = a; bus_RE = 1'b1; bus_WE = 1'b0;
    #1 v = bus_in;
    step();
    idle();
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    step();
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  got [$];
    int          op;
    rst = 1'b0;
    tx_ready = 1'b0;
    idle();
    step();
    step();
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    bus_A = IoBase + 32'h4; bus_RE = 1'b1;
    #1 chk("rst_status", bus_in, 32'h1);
    idle();
    rst = 1'b1;
    step();

    wr(32'h0, 32'h4433_2211);
    wr(32'(RamN - 4), 32'hDDCC_BBAA);
    rd(32'(RamN - 2), v);
    chk("wrap_read", v, 32'h2211_DDCC);
    wr(32'h10, 32'h00F8_458B);
    rd(32'h10, v);
    chk("fetch", v, 32'h00F8_458B);

    for (int i = 1; i <= 9; i++) wr(IoBase, 32'(i));
    rd(IoBase + 32'h4, v);
    chk("status_full", v, 32'h0000_0802);
    chk("overflow_err", {31'h0, err}, 32'h1);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", {24'h0, tx_data}, 32'(i));
      step();
    end
    chk("drained_empty", {31'h0, tx_valid}, 32'h0);

    pulse_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(IoBase, 32'h10 + 32'(i));
    tx_ready = 1'b1;
    wr(IoBase, 32'hAA);
    tx_ready = 1'b0;
    rd(IoBase + 32'h4, v);
    chk("pushpop_count", v, 32'h0000_0802);
    chk("pushpop_err", {31'h0, err}, 32'h0);
    tx_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      got.push_back(tx_data);
      step();
    end
    chk("pushpop_first", {24'h0, got[0]}, 32'h11);
    chk("pushpop_last", {24'h0, got[7]}, 32'hAA);
    chk("pushpop_empty", {31'h0, tx_valid}, 32'h0);

    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(IoBase, 32'h50 + 32'(i));
    tx_ready = 1'b1;
    #3 rst = 1'b0;
    #1 chk("midrst_valid", {31'h0, tx_valid}, 32'h0);
    bus_A = IoBase + 32'h4; bus_RE = 1'b1;
    #1 chk("midrst_status", bus_in, 32'h1);
    idle();
    step();
    #2 rst = 1'b1;
    step();
    rd(32'h0, v);
    chk("ram_kept", v, 32'h4433_2211);

    pulse_reset();
`ifdef Y86_MEM_PERF_EN
    for (int i = 0; i < 5; i++) rd(32'h10, v);
    for (int i = 0; i < 2; i++) wr(32'h100, 32'(i));
    rd(IoBase + 32'h8, v);
    chk("perf_rd", v, 32'd5);
    rd(IoBase + 32'hC, v);
    chk("perf_wr", v, 32'd2);
    wr(IoBase + 32'h8, 32'h0);
    rd(32'h10, v);
    rd(IoBase + 32'h8, v);
    chk("perf_clear", v, 32'd1);
`else
    rd(IoBase + 32'h8, v);
    chk("perf_off_rd", v, 32'h0);
    wr(IoBase + 32'h8, 32'h5);
    rd(IoBase + 32'hC, v);
    chk("perf_off_wr", v, 32'h0);
    chk("perf_off_err", {31'h0, err}, 32'h0);
`endif

    for (int n = 0; n < 2000; n++) begin
      tx_ready = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 11));
      bus_out = $urandom;
      bus_RE = 1'($urandom_range(0, 1));
      bus_WE = 1'($urandom_range(0, 1));
      if (op < 8) begin
        bus_A = $urandom_range(0, 1) ? 32'($urandom_range(0, 63))
                                      : 32'($urandom_range(RamN - 32, RamN - 1));
      end else if (op < 10) begin
        bus_A = IoBase + 32'($urandom_range(0, 3));
      end else begin
        bus_A = IoBase + 32'($urandom_range(4, 15));
      end
      step();
    end
    idle();
    tx_ready = 1'b1;
    repeat (10) step();

    rd(32'h8000_0000, v);
    chk("unmapped_rd", v, 32'h0);
    chk("unmapped_err", {31'h0, err}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
